led_pattern_module: RTL and testbench

LED_PATTERN_MODULE -- requirements
Module: led_pattern_module

---
 rtl/led_pkg.sv | 15 +
 rtl/tick_gen.sv | 45 ++++
 rtl/led_pattern_module.sv | 105 ++++++++++
 tb/tb_led_pattern_module.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern block: mode codes and their width.
package led_pkg;

   localparam int MODE_W = 3;

   // Mode codes carried on Mode_In; codes 5..7 are unused and decode as OFF.
   typedef enum logic [MODE_W-1:0] {
      MODE_OFF    = 3'd0,
      MODE_FLASH  = 3'd1,
      MODE_RUN_L  = 3'd2,
      MODE_RUN_R  = 3'd3,
      MODE_BOUNCE = 3'd4
   } mode_e;

endpackage : led_pkg

// File: rtl/tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 and flags the last count as a tick.
// Clear restarts the count, Hold freezes it (and masks the tick).
module tick_gen #(
   parameter int TICK_DIV = 12_000_000
) (
   input  logic CLK,
   input  logic RST,
   input  logic Clear,
   input  logic Hold,
   output logic Tick
);

   localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;
   logic             at_max;

   assign at_max = (count_reg == CNT_MAX);

   // Tick is decoded from the registered count so it lines up with the
   // edge that updates the pattern; a held prescaler never ticks.
   assign Tick = at_max && !Hold;

   // Next count: clear wins over hold, otherwise advance and wrap.
   always_comb begin
      count_next = count_reg;
      if (Clear) begin
         count_next = '0;
      end else if (!Hold) begin
         count_next = at_max ? '0 : count_reg + CNT_W'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

endmodule : tick_gen

// File: rtl/led_pattern_module.sv
// LED pattern generator: OFF / FLASH / RUN_L / RUN_R / BOUNCE patterns
// stepped once per prescaler tick, with load strobe and pause control.
module led_pattern_module
   import led_pkg::*;
#(
   parameter int N_LED    = 4,
   parameter int TICK_DIV = 12_000_000
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [MODE_W-1:0] Mode_In,
   input  logic              Mode_Valid,
   input  logic              Pause,
   output logic [N_LED-1:0]  LED_Out,
   output logic              Step_Pulse
);

   localparam logic [N_LED-1:0] LSB_ONLY = {{(N_LED-1){1'b0}}, 1'b1};
   localparam logic [N_LED-1:0] MSB_ONLY = {1'b1, {(N_LED-1){1'b0}}};

   logic [MODE_W-1:0] mode_reg;
   logic [MODE_W-1:0] mode_next;
   logic [N_LED-1:0]  led_reg;
   logic [N_LED-1:0]  led_next;
   logic              dir_up_reg;
   logic              dir_up_next;
   logic              tick;

   // Starting pattern shown on the cycle after a mode is loaded.
   function automatic logic [N_LED-1:0] init_pattern(input logic [MODE_W-1:0] m);
      logic [N_LED-1:0] p;
      case (m)
         MODE_RUN_L:  p = LSB_ONLY;
         MODE_RUN_R:  p = MSB_ONLY;
         MODE_BOUNCE: p = LSB_ONLY;
         default:     p = '0;
      endcase
      return p;
   endfunction

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .CLK   (CLK),
      .RST   (RST),
      .Clear (Mode_Valid),
      .Hold  (Pause),
      .Tick  (tick)
   );

   assign Step_Pulse = tick;
   assign LED_Out    = led_reg;

   // Next pattern/direction/mode: a load restarts the mode, otherwise the
   // pattern only moves on a tick (tick is already masked by Pause).
   always_comb begin
      mode_next   = mode_reg;
      led_next    = led_reg;
      dir_up_next = dir_up_reg;
      if (Mode_Valid) begin
         mode_next   = Mode_In;
         led_next    = init_pattern(Mode_In);
         dir_up_next = 1'b1;
      end else if (tick) begin
         case (mode_reg)
            MODE_FLASH: led_next = ~led_reg;
            MODE_RUN_L: led_next = {led_reg[N_LED-2:0], led_reg[N_LED-1]};
            MODE_RUN_R: led_next = {led_reg[0], led_reg[N_LED-1:1]};
            MODE_BOUNCE: begin
               // Reverse at an end so each end is lit for exactly one step.
               if (dir_up_reg) begin
                  if (led_reg[N_LED-1]) begin
                     dir_up_next = 1'b0;
                     led_next    = led_reg >> 1;
                  end else begin
                     led_next    = led_reg << 1;
                  end
               end else begin
                  if (led_reg[0]) begin
                     dir_up_next = 1'b1;
                     led_next    = led_reg << 1;
                  end else begin
                     led_next    = led_reg >> 1;
                  end
               end
            end
            default: led_next = '0;
         endcase
      end
   end

   // Pattern, direction and mode registers; reset overrides load and pause.
   always_ff @(posedge CLK) begin
      if (RST) begin
         mode_reg   <= MODE_OFF;
         led_reg    <= '0;
         dir_up_reg <= 1'b1;
      end else begin
         mode_reg   <= mode_next;
         led_reg    <= led_next;
         dir_up_reg <= dir_up_next;
      end
   end

endmodule : led_pattern_module

// File: tb/tb_led_pattern_module.sv
// Randomized bench for led_pattern_module (N_LED=4, TICK_DIV=4) checked
// every cycle against a position-based reference model.
module tb_led_pattern_module;

   localparam int N_LED    = 4;
   localparam int TICK_DIV = 4;

   logic             clk;
   logic             rst;
   logic [2:0]       mode_in;
   logic             mode_valid;
   logic             pause;
   logic [N_LED-1:0] led_out;
   logic             step_pulse;

   int n_checks;
   int n_fail;

   // Reference model state: prescaler count, mode, lit position, flash phase, direction.
   int m_count;
   int m_mode;
   int m_pos;
   int m_flash_on;
   int m_up;

   led_pattern_module #(
      .N_LED    (N_LED),
      .TICK_DIV (TICK_DIV)
   ) dut (
      .CLK        (clk),
      .RST        (rst),
      .Mode_In    (mode_in),
      .Mode_Valid (mode_valid),
      .Pause      (pause),
      .LED_Out    (led_out),
      .Step_Pulse (step_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_led();
      logic [31:0] v;
      v = 0;
      case (m_mode)
         1: v = m_flash_on ? ((32'd1 << N_LED) - 1) : 32'd0;
         2, 3, 4: v = 32'd1 << m_pos;
         default: v = 0;
      endcase
      return v;
   endfunction

   // Advance the model by one clock edge using the inputs seen at that edge.
   task automatic model_step(input logic r, input logic mv, input int mi, input logic p);
      if (r) begin
         m_mode = 0; m_count = 0; m_up = 1; m_pos = 0; m_flash_on = 0;
      end else if (mv) begin
         m_mode = mi; m_count = 0; m_up = 1; m_flash_on = 0;
         m_pos = (mi == 3) ? N_LED - 1 : 0;
      end else if (!p) begin
         if (m_count == TICK_DIV - 1) begin
            m_count = 0;
            case (m_mode)
               1: m_flash_on = !m_flash_on;
               2: m_pos = (m_pos + 1) % N_LED;
               3: m_pos = (m_pos + N_LED - 1) % N_LED;
               4: begin
                  if (m_up != 0) begin
                     if (m_pos == N_LED - 1) begin m_up = 0; m_pos--; end
                     else m_pos++;
                  end else begin
                     if (m_pos == 0) begin m_up = 1; m_pos++; end
                     else m_pos--;
                  end
               end
               default: ;
            endcase
         end else begin
            m_count++;
         end
      end
   endtask

   task automatic check_outputs(input string ctx);
      logic exp_step;
      exp_step = (m_count == TICK_DIV - 1) && !pause;
      check_value({ctx, "_led"}, 32'(led_out), model_led());
      check_value({ctx, "_step"}, 32'(step_pulse), 32'(exp_step));
   endtask

   // One clocked cycle: drive inputs, model the edge, check after it.
   task automatic cycle(input logic r, input logic mv, input logic [2:0] mi, input logic p, input string ctx);
      rst = r; mode_valid = mv; mode_in = mi; pause = p;
      @(posedge clk);
      model_step(r, mv, int'(mi), p);
      #1;
      check_outputs(ctx);
   endtask

   initial begin
      int pause_left;
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1; mode_valid = 1'b0; mode_in = 3'd0; pause = 1'b0;
      m_count = 0; m_mode = 0; m_pos = 0; m_flash_on = 0; m_up = 1;

      // Reset state, with load and pause asserted to confirm reset wins.
      cycle(1'b1, 1'b1, 3'd2, 1'b1, "reset");
      cycle(1'b1, 1'b0, 3'd0, 1'b0, "reset");
      $display("reset: led=%b step=%b", led_out, step_pulse);

      // Directed walk through each mode for a couple of full sequences.
      for (int m = 1; m <= 7; m++) begin
         cycle(1'b0, 1'b1, 3'(m), 1'b0, "load");
         $display("load mode %0d: led=%b", m, led_out);
         for (int k = 0; k < 9 * TICK_DIV; k++) cycle(1'b0, 1'b0, 3'd0, 1'b0, "run");
      end

      // Randomized traffic: sparse loads, bursts of pause, rare resets.
      pause_left = 0;
      for (int i = 0; i < 3000; i++) begin
         logic r, mv, p;
         logic [2:0] mi;
         r  = ($urandom_range(0, 299) == 0);
         mv = ($urandom_range(0, 39) == 0);
         mi = 3'($urandom_range(0, 7));
         if (pause_left == 0 && $urandom_range(0, 29) == 0) pause_left = $urandom_range(1, 12);
         p = (pause_left != 0);
         if (pause_left != 0) pause_left--;
         cycle(r, mv, mi, p, "rand");
         if (r || mv)
            $display("txn %0d: rst=%b load=%b mode=%0d pause=%b -> led=%b", i, r, mv, mi, p, led_out);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_led_pattern_module
